// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, D_WAIT, I_WAIT} arb_state_t;
  typedef enum logic {GRANT_FETCH, GRANT_DATA} grant_t;

  // addi x0,x0,0 handed back when a fetch is aborted
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline and memory side signals of the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              stall_if;
  logic              stall_pipe;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              bus_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_done, i_rdata, d_done, d_rdata, stall_if, stall_pipe,
           mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_done, i_rdata, d_done, d_rdata, stall_if, stall_pipe,
           mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/arb_timeout_counter.sv
// rtl/arb_timeout_counter.sv - wait-state watchdog counter for one memory access
module arb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory port between fetch and load/store
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] NOP_INSTR      = mem_arb_pkg::NOP_INSTR
) (
  input  logic                CLK,
  input  logic                RSTa,
  mem_port_arbiter_if.slave   bus
);
  arb_state_t state;
  grant_t     last_grant;
  logic       i_pend;
  logic       d_pend;
  logic       grant_d;
  logic       grant_i;
  logic       expired;

  // A requester whose done is pulsing this cycle is finished and must re-request.
  assign i_pend  = bus.i_req & ~bus.i_done;
  assign d_pend  = bus.d_req & ~bus.d_done;
  assign grant_d = d_pend & (~i_pend | (last_grant != GRANT_DATA));
  assign grant_i = i_pend & ~grant_d;

  assign bus.stall_if   = i_pend;
  assign bus.stall_pipe = d_pend;

  arb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (CLK),
    .rst     (RSTa),
    .clear   (state == IDLE),
    .enable  ((state != IDLE) && !bus.mem_ready),
    .expired (expired)
  );

  always_ff @(posedge CLK) begin
    if (RSTa) begin
      state         <= IDLE;
      last_grant    <= GRANT_FETCH;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_done    <= 1'b0;
      bus.d_done    <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.bus_err   <= 1'b0;
    end else begin
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= bus.d_addr[ADDR_W-1:0];
            bus.mem_wdata <= bus.d_wdata[DATA_W-1:0];
            last_grant    <= GRANT_DATA;
            state         <= D_WAIT;
          end else if (grant_i) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.i_addr[ADDR_W-1:0];
            bus.mem_wdata <= bus.d_wdata[DATA_W-1:0];
            last_grant    <= GRANT_FETCH;
            state         <= I_WAIT;
          end
        end
        D_WAIT: begin
          if (bus.mem_ready || expired) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.d_done  <= 1'b1;
            state       <= IDLE;
            if (!bus.mem_we) begin
              bus.d_rdata <= bus.mem_ready ? bus.mem_rdata : '0;
            end
            if (!bus.mem_ready) begin
              bus.bus_err <= 1'b1;
            end
          end
        end
        I_WAIT: begin
          if (bus.mem_ready || expired) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.i_done  <= 1'b1;
            state       <= IDLE;
            bus.i_rdata <= bus.mem_ready ? bus.mem_rdata : NOP_INSTR;
            if (!bus.mem_ready) begin
              bus.bus_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8),
    .NOP_INSTR      (32'h0000_0013)
  ) dut (
    .CLK  (clk),
    .RSTa (rst),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    do_reset();

    // reset state
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_bus_err", bus.bus_err, 0);
    chk("rst_i_rdata", bus.i_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_dones", {bus.i_done, bus.d_done}, 0);

    // ready outside a wait state is ignored
    bus.mem_ready = 1; bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    bus.mem_ready = 0;
    chk("idle_ready_dones", {bus.i_done, bus.d_done}, 0);
    chk("idle_ready_irdata", bus.i_rdata, 0);

    // lone fetch, minimum latency
    bus.i_req = 1; bus.i_addr = 32'h40;
    settle();
    chk("f_stall_if_req", bus.stall_if, 1);
    tick();
    chk("f_mem_req", bus.mem_req, 1);
    chk("f_mem_addr", bus.mem_addr, 32'h40);
    chk("f_mem_we", bus.mem_we, 0);
    chk("f_i_done_early", bus.i_done, 0);
    bus.mem_ready = 1; bus.mem_rdata = 32'h0050_0093;
    tick();
    bus.mem_ready = 0;
    chk("f_i_done", bus.i_done, 1);
    chk("f_i_rdata", bus.i_rdata, 32'h0050_0093);
    chk("f_stall_if_drop", bus.stall_if, 0);
    chk("f_mem_req_drop", bus.mem_req, 0);
    bus.i_req = 0;
    tick();
    chk("f_i_done_pulse", bus.i_done, 0);
    chk("f_no_regrant", bus.mem_req, 0);

    // simultaneous requests after reset: data first, then fetch
    do_reset();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
    bus.i_req = 1; bus.i_addr = 32'h44;
    tick();
    chk("s_d_addr", bus.mem_addr, 32'h100);
    chk("s_d_we", bus.mem_we, 0);
    chk("s_stalls", {bus.stall_pipe, bus.stall_if}, 2'b11);
    tick(); tick();
    chk("s_stall_pipe_wait", bus.stall_pipe, 1);
    tick();
    bus.mem_ready = 1; bus.mem_rdata = 32'hCAFE_0001;
    tick();
    bus.mem_ready = 0;
    chk("s_d_done", bus.d_done, 1);
    chk("s_d_rdata", bus.d_rdata, 32'hCAFE_0001);
    chk("s_stall_pipe_drop", bus.stall_pipe, 0);
    chk("s_i_done_not_yet", bus.i_done, 0);
    bus.d_req = 0;
    tick();
    chk("s_i_addr", bus.mem_addr, 32'h44);
    chk("s_i_mem_req", bus.mem_req, 1);
    chk("s_d_done_pulse", bus.d_done, 0);
    tick(); tick(); tick();
    bus.mem_ready = 1; bus.mem_rdata = 32'h1111_1111;
    tick();
    bus.mem_ready = 0;
    chk("s_i_done", bus.i_done, 1);
    chk("s_i_rdata", bus.i_rdata, 32'h1111_1111);
    bus.i_req = 0;
    tick();

    // fairness with both requests held: D, I, D
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
    bus.i_req = 1; bus.i_addr = 32'h48;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_addr;
      exp_addr = (k == 1) ? 32'h48 : 32'h300;
      tick();
      chk($sformatf("fair_addr_%0d", k), bus.mem_addr, exp_addr);
      bus.mem_ready = 1; bus.mem_rdata = 32'hA000_0000 + k;
      tick();
      bus.mem_ready = 0;
      chk($sformatf("fair_done_%0d", k), {bus.d_done, bus.i_done}, (k == 1) ? 2'b01 : 2'b10);
      if (k == 2) begin
        bus.d_req = 0; bus.i_req = 0;
      end
    end
    chk("fair_d_rdata", bus.d_rdata, 32'hA000_0002);
    chk("fair_i_rdata", bus.i_rdata, 32'hA000_0001);
    tick();

    // store: inputs changed after grant must not reach memory
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEAD_BEEF;
    bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.d_wdata = 32'h0; bus.d_addr = 32'h999; bus.d_we = 0;
    chk("st_mem_we", bus.mem_we, 1);
    chk("st_mem_addr", bus.mem_addr, 32'h200);
    chk("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("st_wdata_held", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("st_addr_held", bus.mem_addr, 32'h200);
    bus.mem_ready = 1;
    tick();
    bus.mem_ready = 0;
    chk("st_d_done", bus.d_done, 1);
    chk("st_d_rdata_kept", bus.d_rdata, 32'hA000_0002);
    bus.d_req = 0;
    tick();
    chk("st_d_done_once", bus.d_done, 0);

    // timeout: abort after 8 wait cycles, sticky bus_err
    bus.i_req = 1; bus.i_addr = 32'h80;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1 || c == 9) begin
        chk($sformatf("to_wait_%0d", c), {bus.mem_req, bus.i_done, bus.bus_err}, 3'b100);
      end
    end
    tick();
    chk("to_i_done", bus.i_done, 1);
    chk("to_i_rdata", bus.i_rdata, 32'h0000_0013);
    chk("to_bus_err", bus.bus_err, 1);
    chk("to_mem_req", bus.mem_req, 0);
    bus.i_req = 0;
    tick(); tick();
    chk("to_bus_err_sticky", bus.bus_err, 1);

    // reset in the middle of a load
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h104;
    tick();
    chk("rm_mem_req", bus.mem_req, 1);
    rst = 1; bus.d_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h5555_5555;
    tick();
    rst = 0; bus.mem_ready = 0;
    chk("rm_mem_req_off", bus.mem_req, 0);
    chk("rm_bus_err", bus.bus_err, 0);
    chk("rm_no_done", bus.d_done, 0);
    tick();
    chk("rm_no_done_late", {bus.d_done, bus.mem_req}, 0);
    chk("rm_d_rdata", bus.d_rdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
